// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first with repeat count and idle gaps.
// Optional even-parity bit per frame when SEQ_TX_PARITY_EN is defined.
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int LEN_W = 3,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state
);

    // Handshake: start is sampled only while busy=0; busy stays high until the
    // cycle after the single-cycle done pulse, when start is accepted again.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_GAP  = 3'd2,
        S_DONE = 3'd3
`ifdef SEQ_TX_PARITY_EN
        , S_PAR = 3'd4
`endif
    } state_t;

    state_t             state, state_n;
    logic [LEN_W-1:0]   idx, idx_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic [REP_W-1:0]   frames_left, frames_n;
    logic [GAP_W-1:0]   gap_cnt, gcnt_n;
    logic [GAP_W-1:0]   gap_q, gap_n;
    logic [PAT_W-1:0]   pat_q, pat_n;
    logic [LEN_W-1:0]   len_clamp;
    logic               frame_end;
    logic               x_n;

`ifdef SEQ_TX_PARITY_EN
    function automatic logic even_parity(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l);
        logic r;
        r = 1'b0;
        for (int i = 0; i < PAT_W; i++) begin
            if (LEN_W'(i) < l) r = r ^ p[i];
        end
        return r;
    endfunction
`endif

    assign len_clamp = (pat_len == '0 || pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
    assign dbg_state = state;

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        len_n     = len_q;
        frames_n  = frames_left;
        gcnt_n    = gap_cnt;
        gap_n     = gap_q;
        pat_n     = pat_q;
        frame_end = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    pat_n    = pattern;
                    len_n    = len_clamp;
                    frames_n = (reps == '0) ? REP_W'(1) : reps;
                    gap_n    = gap;
                    idx_n    = len_clamp - LEN_W'(1);
                    state_n  = S_SEND;
                end
            end
            S_SEND: begin
                if (en) begin
                    if (idx != '0) begin
                        idx_n = idx - LEN_W'(1);
                    end else begin
`ifdef SEQ_TX_PARITY_EN
                        state_n = S_PAR;
`else
                        frame_end = 1'b1;
`endif
                    end
                end
            end
`ifdef SEQ_TX_PARITY_EN
            S_PAR: begin
                if (en) frame_end = 1'b1;
            end
`endif
            S_GAP: begin
                if (en) begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        state_n = S_SEND;
                        idx_n   = len_q - LEN_W'(1);
                    end else begin
                        gcnt_n = gap_cnt - GAP_W'(1);
                    end
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Shared end-of-frame decision for the plain and parity frame formats.
        if (frame_end) begin
            frames_n = frames_left - REP_W'(1);
            if (frames_left > REP_W'(1)) begin
                if (gap_q != '0) begin
                    state_n = S_GAP;
                    gcnt_n  = gap_q;
                end else begin
                    state_n = S_SEND;
                    idx_n   = len_q - LEN_W'(1);
                end
            end else begin
                state_n = S_DONE;
            end
        end

        x_n = 1'b0;
        if (state_n == S_SEND) x_n = |(pat_n & (PAT_W'(1) << idx_n));
`ifdef SEQ_TX_PARITY_EN
        if (state_n == S_PAR) x_n = even_parity(pat_n, len_n);
`endif
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            len_q       <= '0;
            frames_left <= '0;
            gap_cnt     <= '0;
            gap_q       <= '0;
            pat_q       <= '0;
            x           <= 1'b0;
            x_valid     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            len_q       <= len_n;
            frames_left <= frames_n;
            gap_cnt     <= gcnt_n;
            gap_q       <= gap_n;
            pat_q       <= pat_n;
            x           <= x_n;
`ifdef SEQ_TX_PARITY_EN
            x_valid     <= (state_n == S_SEND) || (state_n == S_PAR);
`else
            x_valid     <= (state_n == S_SEND);
`endif
            busy        <= (state_n != S_IDLE);
            done        <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: vector table of transfers, bit scoreboard, reset corner cases.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       start;
    logic [3:0] pattern;
    logic [2:0] pat_len;
    logic [3:0] reps;
    logic [3:0] gap;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;
    logic [2:0] dbg_state;

    int total = 0;
    int bad   = 0;
    logic [0:0] exp_q[$];

    typedef struct {
        logic [3:0]  pattern;
        logic [2:0]  pat_len;
        logic [3:0]  reps;
        logic [3:0]  gap;
        bit          toggle;
        logic [15:0] bits;
        int          nbits;
        int          nbusy;
        int          ngap;
    } vec_t;

    vec_t vecs[8];

    seq_pattern_tx dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .pattern(pattern), .pat_len(pat_len), .reps(reps), .gap(gap),
        .x(x), .x_valid(x_valid), .busy(busy), .done(done),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] p, input logic [2:0] l, input logic [3:0] r,
                                input logic [3:0] g, input bit t, input logic [15:0] b,
                                input int nb, input int nbu, input int ng);
        vec_t v;
        v.pattern = p; v.pat_len = l; v.reps = r; v.gap = g; v.toggle = t;
        v.bits = b; v.nbits = nb; v.nbusy = nbu; v.ngap = ng;
        return v;
    endfunction

    task automatic run_vec(input int i);
        vec_t v;
        int   n_busy, n_gap, n_done;
        bit   seen_done, finished;
        v = vecs[i];
        exp_q.delete();
        for (int k = v.nbits - 1; k >= 0; k--) exp_q.push_back(v.bits[k]);
        pattern = v.pattern; pat_len = v.pat_len; reps = v.reps; gap = v.gap;
        en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble config inputs: the transfer must use the latched copy.
        pattern = ~v.pattern; pat_len = 3'd2; reps = 4'd7; gap = 4'd5;
        if (v.toggle) en = 1'b0;
        n_busy = 0; n_gap = 0; n_done = 0; seen_done = 0; finished = 0;
        for (int c = 0; c < 200 && !finished; c++) begin
            @(negedge clk);
            if (c == 0) check("first_valid", x_valid, 1);
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                seen_done = 1;
                check("done_no_valid", x_valid, 0);
            end
            if (busy && !x_valid && !done) n_gap++;
            if (x_valid) begin
                if (exp_q.size() == 0) check("extra_bit", 1, 0);
                else begin
                    check("bit", x, exp_q[0]);
                    if (en) void'(exp_q.pop_front());
                end
            end else if (x !== 1'b0) begin
                check("x_idle", x, 0);
            end
            if (seen_done && !busy) finished = 1;
            if (!finished) begin
                @(posedge clk); #1;
                start = (c == 1);
                if (v.toggle) en = ~en;
            end
        end
        start = 1'b0;
        check("timeout", finished, 1);
        check("queue_empty", exp_q.size(), 0);
        check("done_count", n_done, 1);
        check("busy_cycles", n_busy, v.nbusy);
        check("gap_cycles", n_gap, v.ngap);
    endtask

    initial begin
`ifdef SEQ_TX_PARITY_EN
        vecs[0] = mk(4'b1010, 3'd4, 4'd2, 4'd0, 0, 16'b1010010100, 10, 11, 0);
        vecs[1] = mk(4'b1010, 3'd4, 4'd3, 4'd2, 0, 16'b101001010010100, 15, 20, 4);
        vecs[2] = mk(4'b0110, 3'd3, 4'd0, 4'd0, 1, 16'b1100, 4, 9, 0);
        vecs[3] = mk(4'b1101, 3'd0, 4'd1, 4'd3, 0, 16'b11011, 5, 6, 0);
        vecs[4] = mk(4'b0011, 3'd7, 4'd2, 4'd1, 0, 16'b0011000110, 10, 12, 1);
        vecs[5] = mk(4'b0001, 3'd1, 4'd3, 4'd0, 0, 16'b111111, 6, 7, 0);
        vecs[6] = mk(4'b0100, 3'd1, 4'd2, 4'd2, 0, 16'b0000, 4, 7, 2);
        vecs[7] = mk(4'b1011, 3'd4, 4'd1, 4'd0, 0, 16'b10111, 5, 6, 0);
`else
        vecs[0] = mk(4'b1010, 3'd4, 4'd2, 4'd0, 0, 16'b10101010, 8, 9, 0);
        vecs[1] = mk(4'b1010, 3'd4, 4'd3, 4'd2, 0, 16'b101010101010, 12, 17, 4);
        vecs[2] = mk(4'b0110, 3'd3, 4'd0, 4'd0, 1, 16'b110, 3, 7, 0);
        vecs[3] = mk(4'b1101, 3'd0, 4'd1, 4'd3, 0, 16'b1101, 4, 5, 0);
        vecs[4] = mk(4'b0011, 3'd7, 4'd2, 4'd1, 0, 16'b00110011, 8, 10, 1);
        vecs[5] = mk(4'b0001, 3'd1, 4'd3, 4'd0, 0, 16'b111, 3, 4, 0);
        vecs[6] = mk(4'b0100, 3'd1, 4'd2, 4'd2, 0, 16'b00, 2, 5, 2);
        vecs[7] = mk(4'b1011, 3'd4, 4'd1, 4'd0, 0, 16'b1011, 4, 5, 0);
`endif

        // Clock/reset block
        rst = 1'b1; en = 1'b0; start = 1'b0;
        pattern = '0; pat_len = '0; reps = '0; gap = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("reset_idle", {x, x_valid, busy, done}, 0);
        end

        // Table vectors, each started in the IDLE cycle right after the previous one.
        for (int i = 0; i < 8; i++) run_vec(i);

        // Reset in the middle of bit 2 of frame 1.
        pattern = 4'b1010; pat_len = 3'd4; reps = 4'd2; gap = 4'd0;
        en = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1 check("rst_mid_outputs", {x, x_valid, busy, done}, 0);
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rst_no_done", {busy, done}, 0);
        end
        run_vec(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
